controller: RTL

Control unit for the single-cycle ARM-subset processor. Decodes the instruction currently presented by instruction memory and drives every select and enable of the datapath. Holds the architectural NZCV flags register and evaluates the condition field so that failing instructions have no architectural effect. Sits directly upstream of the datapath: it consumes the datapath's `aluflags` and produces its `regsrc`/`regwrite`/`immsrc`/`alusrc`/`alucontrol`/`memtoreg`/`pcsrc`, plus `memwrite` for data memory.

---
 rtl/controller.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/controller.sv
// Control unit for the single-cycle ARM-subset processor: main/ALU decode,
// condition evaluation and the NZCV flags register.
module controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] instr,
    input  logic [3:0]  aluflags,
    output logic [1:0]  regsrc,
    output logic        regwrite,
    output logic [1:0]  immsrc,
    output logic        alusrc,
    output logic [1:0]  alucontrol,
    output logic        memtoreg,
    output logic        memwrite,
    output logic        pcsrc
);

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // instr carries bits [31:12] of the instruction word.
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] cmd;
    logic       s_bit;
    logic       unused_rn;

    assign cond      = instr[19:16];
    assign op        = instr[15:14];
    assign funct     = instr[13:8];
    assign rd        = instr[3:0];
    assign cmd       = funct[4:1];
    assign s_bit     = funct[0];
    assign unused_rn = ^instr[7:4];

    logic       reg_w_main;
    logic       mem_w_main;
    logic       branch;
    logic       alu_op;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        regsrc     = 2'b00;
        immsrc     = 2'b00;
        alusrc     = 1'b0;
        memtoreg   = 1'b0;
        reg_w_main = 1'b0;
        mem_w_main = 1'b0;
        branch     = 1'b0;
        alu_op     = 1'b0;
        case (op)
            OP_DP: begin
                alusrc     = funct[5];
                reg_w_main = 1'b1;
                alu_op     = 1'b1;
            end
            OP_MEM: begin
                immsrc = 2'b01;
                alusrc = 1'b1;
                if (funct[0]) begin
                    memtoreg   = 1'b1;
                    reg_w_main = 1'b1;
                end else begin
                    regsrc     = 2'b10;
                    mem_w_main = 1'b1;
                end
            end
            OP_BR: begin
                regsrc = 2'b01;
                immsrc = 2'b10;
                alusrc = 1'b1;
                branch = 1'b1;
            end
            default: ;
        endcase
    end

    logic cmd_valid;

    always_comb begin
        alucontrol = ALU_ADD;
        cmd_valid  = 1'b1;
        if (alu_op) begin
            case (cmd)
                CMD_ADD: alucontrol = ALU_ADD;
                CMD_SUB: alucontrol = ALU_SUB;
                CMD_AND: alucontrol = ALU_AND;
                CMD_ORR: alucontrol = ALU_ORR;
                default: cmd_valid  = 1'b0;
            endcase
        end
    end

    logic       reg_w;
    logic       mem_w;
    logic       pcs;
    logic [1:0] flag_w;

    // An unsupported data-processing command must have no architectural effect.
    assign reg_w     = reg_w_main & cmd_valid;
    assign mem_w     = mem_w_main & cmd_valid;
    assign flag_w[1] = s_bit & alu_op & cmd_valid;
    assign flag_w[0] = flag_w[1] & ((cmd == CMD_ADD) | (cmd == CMD_SUB));
    assign pcs       = branch | (reg_w & (rd == 4'hF));

    logic [1:0] flags_nz;
    logic [1:0] flags_cv;
    logic       n_flag, z_flag, c_flag, v_flag;
    logic       cond_ex;

    assign {n_flag, z_flag} = flags_nz;
    assign {c_flag, v_flag} = flags_cv;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z_flag;
            COND_NE: cond_ex = ~z_flag;
            COND_CS: cond_ex = c_flag;
            COND_CC: cond_ex = ~c_flag;
            COND_MI: cond_ex = n_flag;
            COND_PL: cond_ex = ~n_flag;
            COND_VS: cond_ex = v_flag;
            COND_VC: cond_ex = ~v_flag;
            COND_HI: cond_ex = c_flag & ~z_flag;
            COND_LS: cond_ex = ~c_flag | z_flag;
            COND_GE: cond_ex = (n_flag == v_flag);
            COND_LT: cond_ex = (n_flag != v_flag);
            COND_GT: cond_ex = ~z_flag & (n_flag == v_flag);
            COND_LE: cond_ex = z_flag | (n_flag != v_flag);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_nz <= 2'b00;
            flags_cv <= 2'b00;
        end else begin
            if (flag_w[1] & cond_ex) flags_nz <= aluflags[3:2];
            if (flag_w[0] & cond_ex) flags_cv <= aluflags[1:0];
        end
    end

    // Architectural side effects are suppressed while reset is held.
    logic exec;

    assign exec     = cond_ex & ~reset;
    assign regwrite = reg_w & exec;
    assign memwrite = mem_w & exec;
    assign pcsrc    = pcs & exec;

endmodule
